// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: credit-based instruction fetch sequencer.
// Issues word-aligned reads and tracks in-flight reads. Responses land in a
// small registered queue feeding decode. A redirect restarts fetch at the
// new target and silently drops responses still returning from the old path.
module rv_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          QUEUE_DEPTH     = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_decode_pc_sel,
  input  logic [31:2] i_decode_pc_target,
  input  logic        i_exec_pc_sel,
  input  logic [31:2] i_exec_pc_target,
  output logic        o_mem_req,
  output logic [31:2] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:2] o_instr_pc,
  output logic        o_flushing
);

  localparam int          PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [31:2] RESET_PC = RESET_ADDR[31:2];
  localparam logic [4:0]  DEPTH_W5 = 5'(QUEUE_DEPTH);
  localparam logic [2:0]  MAX_W3   = 3'(MAX_OUTSTANDING);

  // architectural state
  logic [31:2]      fetch_pc_r, resp_pc_r;
  logic [2:0]       out_cnt_r, drop_cnt_r;
  logic [CNT_W-1:0] q_count_r;
  logic [PTR_W-1:0] q_wr_ptr_r, q_rd_ptr_r;
  logic [31:0]      q_instr_r [QUEUE_DEPTH];
  logic [31:2]      q_pc_r    [QUEUE_DEPTH];

  // next-state values
  logic [31:2]      fetch_pc_nxt_s, resp_pc_nxt_s;
  logic [2:0]       out_cnt_nxt_s, drop_cnt_nxt_s;
  logic [CNT_W-1:0] q_count_nxt_s;
  logic [PTR_W-1:0] q_wr_ptr_nxt_s, q_rd_ptr_nxt_s;

  // per-cycle decisions
  logic        redir_s, grant_s, rvalid_s, accept_s, pop_s;
  logic        mem_req_s, instr_valid_s;
  logic [31:2] target_s;
  logic [4:0]  credit_use_s;

  // Execute redirect wins; requests are withheld on any redirect cycle.
  // Credits: live (non-stale) reads plus queued entries must leave a free slot,
  // so every accepted response is guaranteed a queue entry.
  assign redir_s       = i_exec_pc_sel | i_decode_pc_sel;
  assign target_s      = i_exec_pc_sel ? i_exec_pc_target : i_decode_pc_target;
  assign credit_use_s  = 5'(out_cnt_r) - 5'(drop_cnt_r) + 5'(q_count_r);
  assign mem_req_s     = !i_reset & !redir_s & (out_cnt_r < MAX_W3) & (credit_use_s < DEPTH_W5);
  assign grant_s       = mem_req_s & i_mem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rvalid_s      = i_mem_rvalid & (out_cnt_r != 3'd0);
  assign accept_s      = rvalid_s & !redir_s & (drop_cnt_r == 3'd0);
  assign instr_valid_s = !i_reset & !redir_s & (q_count_r != {CNT_W{1'b0}});
  assign pop_s         = instr_valid_s & i_instr_ready;

  assign o_mem_req     = mem_req_s;
  assign o_mem_addr    = i_reset ? RESET_PC : fetch_pc_r;
  assign o_instr_valid = instr_valid_s;
  assign o_instr       = instr_valid_s ? q_instr_r[q_rd_ptr_r] : 32'h0000_0000;
  assign o_instr_pc    = instr_valid_s ? q_pc_r[q_rd_ptr_r] : 30'h0000_0000;
  assign o_flushing    = !i_reset & (drop_cnt_r != 3'd0);

  // Next-state for PCs, read counters and queue bookkeeping.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    resp_pc_nxt_s  = resp_pc_r;
    out_cnt_nxt_s  = out_cnt_r;
    drop_cnt_nxt_s = drop_cnt_r;
    q_count_nxt_s  = q_count_r;
    q_wr_ptr_nxt_s = q_wr_ptr_r;
    q_rd_ptr_nxt_s = q_rd_ptr_r;

    case ({grant_s, rvalid_s})
      2'b10:   out_cnt_nxt_s = out_cnt_r + 3'd1;
      2'b01:   out_cnt_nxt_s = out_cnt_r - 3'd1;
      default: out_cnt_nxt_s = out_cnt_r;
    endcase

    if (redir_s) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_nxt_s = target_s;
      resp_pc_nxt_s  = target_s;
      drop_cnt_nxt_s = out_cnt_r - {2'b00, rvalid_s};
      q_count_nxt_s  = {CNT_W{1'b0}};
      q_wr_ptr_nxt_s = {PTR_W{1'b0}};
      q_rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      if (grant_s) begin
        fetch_pc_nxt_s = fetch_pc_r + 30'd1;
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      if (accept_s) begin
        resp_pc_nxt_s  = resp_pc_r + 30'd1;
        q_wr_ptr_nxt_s = q_wr_ptr_r + PTR_W'(1);
      end else begin
        resp_pc_nxt_s  = resp_pc_r;
        q_wr_ptr_nxt_s = q_wr_ptr_r;
      end
      if (rvalid_s && (drop_cnt_r != 3'd0)) begin
        drop_cnt_nxt_s = drop_cnt_r - 3'd1;
      end else begin
        drop_cnt_nxt_s = drop_cnt_r;
      end
      if (pop_s) begin
        q_rd_ptr_nxt_s = q_rd_ptr_r + PTR_W'(1);
      end else begin
        q_rd_ptr_nxt_s = q_rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   q_count_nxt_s = q_count_r + CNT_W'(1);
        2'b01:   q_count_nxt_s = q_count_r - CNT_W'(1);
        default: q_count_nxt_s = q_count_r;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      out_cnt_r  <= 3'd0;
      drop_cnt_r <= 3'd0;
      q_count_r  <= {CNT_W{1'b0}};
      q_wr_ptr_r <= {PTR_W{1'b0}};
      q_rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      resp_pc_r  <= resp_pc_nxt_s;
      out_cnt_r  <= out_cnt_nxt_s;
      drop_cnt_r <= drop_cnt_nxt_s;
      q_count_r  <= q_count_nxt_s;
      q_wr_ptr_r <= q_wr_ptr_nxt_s;
      q_rd_ptr_r <= q_rd_ptr_nxt_s;
    end
  end

  // Queue storage: written with the accepted response and its fetch address.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr_r[i] <= 32'h0000_0000;
        q_pc_r[i]    <= 30'h0000_0000;
      end
    end else if (accept_s) begin
      q_instr_r[q_wr_ptr_r] <= i_mem_rdata;
      q_pc_r[q_wr_ptr_r]    <= resp_pc_r;
    end
  end

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb_rv_fetch_ctrl: random and directed stimulus against a transaction-level
// reference model (reads tagged with a path epoch, queue of delivered words).
module tb_rv_fetch_ctrl;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0100;
  localparam int          DEPTH      = 2;
  localparam int          MAXO       = 2;
  localparam logic [29:0] RESET_WORD = 30'h0000_0040;

  logic        i_clk, i_reset;
  logic        i_decode_pc_sel, i_exec_pc_sel;
  logic [29:0] i_decode_pc_target, i_exec_pc_target;
  logic        o_mem_req, i_mem_gnt, i_mem_rvalid;
  logic [29:0] o_mem_addr;
  logic [31:0] i_mem_rdata;
  logic        o_instr_valid, i_instr_ready, o_flushing;
  logic [31:0] o_instr;
  logic [29:0] o_instr_pc;

  rv_fetch_ctrl #(
    .RESET_ADDR(RESET_ADDR), .QUEUE_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_decode_pc_sel(i_decode_pc_sel), .i_decode_pc_target(i_decode_pc_target),
    .i_exec_pc_sel(i_exec_pc_sel), .i_exec_pc_target(i_exec_pc_target),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_flushing(o_flushing)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct { logic [29:0] addr; int epoch; int gcyc; } rd_t;
  typedef struct { logic [31:0] instr; logic [29:0] pc; } ent_t;

  rd_t         inflight[$];  // granted, unanswered reads in bus order
  ent_t        mq[$];        // instructions delivered and not yet consumed
  logic [29:0] m_fetch;
  int          m_epoch;
  int          cyc, checks, failures;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [29:0] rand_tgt();
    case ($urandom_range(0, 2))
      0:       return 30'h3FFF_FFFE + 30'($urandom_range(0, 1));
      1:       return 30'($urandom_range(0, 255));
      default: return 30'($urandom);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input logic rst, input logic dsel, input logic [29:0] dtgt,
                      input logic esel, input logic [29:0] etgt,
                      input logic gnt, input logic rvw, input logic rdy);
    rd_t         r;
    ent_t        e;
    int          live;
    logic        redir, exp_req, exp_valid, exp_flush, rv, acc;
    logic [29:0] tgt;
    @(negedge i_clk);
    rv = !rst && rvw && (inflight.size() > 0) && (inflight[0].gcyc < cyc);
    i_reset            = rst;
    i_decode_pc_sel    = dsel;
    i_decode_pc_target = dtgt;
    i_exec_pc_sel      = esel;
    i_exec_pc_target   = etgt;
    i_mem_gnt          = gnt;
    i_mem_rvalid       = rv;
    i_mem_rdata        = rv ? mem_word(inflight[0].addr) : $urandom;
    i_instr_ready      = rdy;
    #1;
    if (rst) begin
      check_eq("rst_req",   32'(o_mem_req),     32'd0);
      check_eq("rst_addr",  32'(o_mem_addr),    32'(RESET_WORD));
      check_eq("rst_valid", 32'(o_instr_valid), 32'd0);
      check_eq("rst_instr", o_instr,            32'd0);
      check_eq("rst_pc",    32'(o_instr_pc),    32'd0);
      check_eq("rst_flush", 32'(o_flushing),    32'd0);
      inflight.delete();
      mq.delete();
      m_fetch = RESET_WORD;
      m_epoch++;
    end else begin
      redir = dsel | esel;
      tgt   = esel ? etgt : dtgt;
      live  = 0;
      exp_flush = 1'b0;
      foreach (inflight[i]) begin
        if (inflight[i].epoch == m_epoch) live++;
        else exp_flush = 1'b1;
      end
      exp_req   = !redir && (inflight.size() < MAXO) && (live + mq.size() < DEPTH);
      exp_valid = !redir && (mq.size() > 0);
      check_eq("mem_req",  32'(o_mem_req),     32'(exp_req));
      check_eq("mem_addr", 32'(o_mem_addr),    32'(m_fetch));
      check_eq("valid",    32'(o_instr_valid), 32'(exp_valid));
      check_eq("flushing", 32'(o_flushing),    32'(exp_flush));
      if (exp_valid) begin
        check_eq("instr",    o_instr,          mq[0].instr);
        check_eq("instr_pc", 32'(o_instr_pc),  32'(mq[0].pc));
      end
      acc = 1'b0;
      if (rv) begin
        r   = inflight.pop_front();
        acc = !redir && (r.epoch == m_epoch);
      end
      if (exp_valid && rdy) void'(mq.pop_front());
      if (redir) begin
        m_epoch++;
        mq.delete();
        m_fetch = tgt;
      end else begin
        if (acc) begin
          e.instr = mem_word(r.addr);
          e.pc    = r.addr;
          mq.push_back(e);
        end
        if (exp_req && gnt) begin
          r.addr  = m_fetch;
          r.epoch = m_epoch;
          r.gcyc  = cyc;
          inflight.push_back(r);
          m_fetch = m_fetch + 30'd1;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    logic        rs, ds, es, g, rvw, rdy;
    logic [29:0] dt, et;
    checks = 0; failures = 0; cyc = 0; m_epoch = 0; m_fetch = RESET_WORD;
    i_reset = 1'b1; i_decode_pc_sel = 1'b0; i_exec_pc_sel = 1'b0;
    i_decode_pc_target = 30'd0; i_exec_pc_target = 30'd0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0; i_instr_ready = 1'b1;

    // reset, then streaming with immediate grant and 1-cycle responses
    repeat (3) step(1'b1, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b1);
    // decode stall then drain
    repeat (10) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b1);
    // build outstanding reads, exec redirect to byte 0x80
    repeat (2) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 30'd0, 1'b1, 30'h20, 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b1);
    // simultaneous decode 0x200 / exec 0x300 redirect
    step(1'b0, 1'b1, 30'h80, 1'b1, 30'hC0, 1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b1);
    // fill the queue under stall, then redirect together with a response
    repeat (4) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 30'h123, 1'b0, 30'd0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b1);
    // reset mid-stream with a read outstanding
    step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 30'd0, 1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 30'd0, 1'b0, 30'd0, 1'b1, 1'b1, 1'b1);

    // randomized traffic, alternating free-flowing and stall-heavy phases
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 199) == 0);
      ds  = ($urandom_range(0, 15) == 0);
      es  = ($urandom_range(0, 19) == 0);
      dt  = rand_tgt();
      et  = rand_tgt();
      g   = ($urandom_range(0, 3) != 0);
      rvw = ($urandom_range(0, 2) != 0);
      rdy = ((n / 500) % 2 == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
      step(rs, ds, dt, es, et, g, rvw, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
